// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: arbitrates I-cache misses, D-cache misses and write-through
// stores onto one pipelined main memory. Block fills are issued one read per cycle
// and the returned words are streamed back to the requesting cache as they arrive.
// busy holds the pipeline for as long as a fill or store is in flight.
module cache_fill_arbiter #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               icache_miss,
  input  logic [ADDR_W-1:0]                  icache_addr,
  input  logic                               dcache_miss,
  input  logic [ADDR_W-1:0]                  dcache_addr,
  input  logic                               store_req,
  input  logic [ADDR_W-1:0]                  store_addr,
  input  logic [DATA_W-1:0]                  store_data,
  output logic                               mem_enable,
  output logic                               mem_wr,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic [DATA_W-1:0]                  mem_data_in,
  input  logic                               mem_data_valid,
  input  logic [DATA_W-1:0]                  mem_data_out,
  output logic [DATA_W-1:0]                  fill_data,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
  output logic                               fill_we_i,
  output logic                               fill_we_d,
  output logic                               fill_done_i,
  output logic                               fill_done_d,
  output logic                               store_done,
  output logic                               busy
);

  localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
  // byte offset within a block: word index plus the byte-in-word bit
  localparam int OFF_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [CNT_W:0]    WPB_CNT   = (CNT_W + 1)'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, WRITE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] blkAddr;
  // number of block reads issued so far, including the one on the bus this cycle
  logic [CNT_W:0]    issuedCnt;
  logic [CNT_W-1:0]  recvCnt;
  logic              isFill;
  logic              wordAccept;
  logic [ADDR_W-1:0] nextIssueAddr;

  // A returned word is only taken during a fill and only if a read for it was
  // already issued, so stale responses from an aborted fill cannot be counted.
  assign isFill        = (state == FILL_I) || (state == FILL_D);
  assign wordAccept    = isFill && mem_data_valid && ({1'b0, recvCnt} < issuedCnt);
  assign nextIssueAddr = blkAddr | ADDR_W'({issuedCnt[CNT_W-1:0], 1'b0});

  // Arbitration FSM; memory-side outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      blkAddr     <= '0;
      issuedCnt   <= '0;
      recvCnt     <= '0;
      mem_enable  <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      store_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_enable  <= 1'b0;
          mem_wr      <= 1'b0;
          mem_addr    <= '0;
          mem_data_in <= '0;
          store_done  <= 1'b0;
          issuedCnt   <= '0;
          recvCnt     <= '0;
          if (dcache_miss) begin
            state      <= FILL_D;
            blkAddr    <= dcache_addr & ~OFF_MASK;
            mem_enable <= 1'b1;
            mem_addr   <= dcache_addr & ~OFF_MASK;
            issuedCnt  <= (CNT_W + 1)'(1);
          end else if (store_req) begin
            state       <= WRITE;
            mem_enable  <= 1'b1;
            mem_wr      <= 1'b1;
            mem_addr    <= store_addr;
            mem_data_in <= store_data;
            store_done  <= 1'b1;
          end else if (icache_miss) begin
            state      <= FILL_I;
            blkAddr    <= icache_addr & ~OFF_MASK;
            mem_enable <= 1'b1;
            mem_addr   <= icache_addr & ~OFF_MASK;
            issuedCnt  <= (CNT_W + 1)'(1);
          end
        end
        FILL_I, FILL_D: begin
          if (issuedCnt < WPB_CNT) begin
            mem_enable <= 1'b1;
            mem_addr   <= nextIssueAddr;
            issuedCnt  <= issuedCnt + (CNT_W + 1)'(1);
          end else begin
            mem_enable <= 1'b0;
            mem_addr   <= '0;
          end
          if (wordAccept) begin
            recvCnt <= recvCnt + CNT_W'(1);
            if (recvCnt == LAST_WORD) begin
              state      <= IDLE;
              mem_enable <= 1'b0;
              mem_addr   <= '0;
              issuedCnt  <= '0;
              recvCnt    <= '0;
            end
          end
        end
        WRITE: begin
          state       <= IDLE;
          mem_enable  <= 1'b0;
          mem_wr      <= 1'b0;
          mem_addr    <= '0;
          mem_data_in <= '0;
          store_done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Fill strobes follow the returning data in the same cycle it arrives.
  assign fill_we_i   = wordAccept && (state == FILL_I);
  assign fill_we_d   = wordAccept && (state == FILL_D);
  assign fill_data   = wordAccept ? mem_data_out : '0;
  assign fill_word   = wordAccept ? recvCnt : '0;
  assign fill_done_i = fill_we_i && (recvCnt == LAST_WORD);
  assign fill_done_d = fill_we_d && (recvCnt == LAST_WORD);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: directed scenarios with hand-computed checkpoints,
// then randomized request traffic against a transaction-level reference model.
module tb_cache_fill_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int WPB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          icache_miss = 1'b0, dcache_miss = 1'b0, store_req = 1'b0;
  logic [AW-1:0] icache_addr = '0, dcache_addr = '0, store_addr = '0;
  logic [DW-1:0] store_data = '0;
  logic          mem_enable, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic          mem_data_valid = 1'b0;
  logic [DW-1:0] mem_data_out = '0;
  logic [DW-1:0] fill_data;
  logic [2:0]    fill_word;
  logic          fill_we_i, fill_we_d, fill_done_i, fill_done_d, store_done, busy;

  always #5 clk = ~clk;

  cache_fill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLOCK(WPB)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_miss(icache_miss), .icache_addr(icache_addr),
    .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
    .store_req(store_req), .store_addr(store_addr), .store_data(store_data),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_valid(mem_data_valid), .mem_data_out(mem_data_out),
    .fill_data(fill_data), .fill_word(fill_word),
    .fill_we_i(fill_we_i), .fill_we_d(fill_we_d),
    .fill_done_i(fill_done_i), .fill_done_d(fill_done_d),
    .store_done(store_done), .busy(busy)
  );

  int nVec = 0;
  int nMis = 0;
  int cycleNo = 0;
  int lat = 4;
  bit spurEn = 1'b0;
  bit forceSpur = 1'b0;

  // reference model: the job occupying the current cycle (0 none, 1 D fill, 2 I fill, 3 store)
  int          jobKind = 0;
  int          jobK = 0;
  logic [15:0] jobAddr = '0;
  logic [15:0] jobData = '0;

  // memory model: responses scheduled by cycle number
  bit          slotV [32];
  logic [15:0] slotA [32];

  function automatic logic [15:0] memWord(logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C96;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cycleNo, act, exp);
    end
  endtask

  function automatic bit jobLast();
    if (jobKind == 3) return 1'b1;
    if (jobKind == 1 || jobKind == 2) return jobK == lat + WPB - 1;
    return 1'b0;
  endfunction

  // Decide which job occupies the next cycle from the current job and the requests.
  task automatic modelAdvance();
    if (!rst_n) begin
      jobKind = 0;
    end else if (jobKind != 0 && !jobLast()) begin
      jobK++;
    end else if (jobKind != 0) begin
      jobKind = 0;
    end else if (dcache_miss) begin
      jobKind = 1; jobK = 0; jobAddr = dcache_addr & 16'hFFF0;
    end else if (store_req) begin
      jobKind = 3; jobK = 0; jobAddr = store_addr; jobData = store_data;
    end else if (icache_miss) begin
      jobKind = 2; jobK = 0; jobAddr = icache_addr & 16'hFFF0;
    end
  endtask

  task automatic compareNow();
    logic        eEn, eWr, eSd, eBusy, eWeI, eWeD, eDoneI, eDoneD;
    logic [15:0] eAddr, eDin, eData;
    logic [2:0]  eWord;
    int          w;
    eEn = 0; eWr = 0; eSd = 0; eBusy = 0; eWeI = 0; eWeD = 0; eDoneI = 0; eDoneD = 0;
    eAddr = '0; eDin = '0; eData = '0; eWord = '0;
    if (jobKind == 3) begin
      eEn = 1; eWr = 1; eAddr = jobAddr; eDin = jobData; eSd = 1; eBusy = 1;
    end else if (jobKind != 0) begin
      eBusy = 1;
      if (jobK < WPB) begin
        eEn = 1;
        eAddr = 16'(jobAddr + 2 * jobK);
      end
      w = jobK - lat;
      if (w >= 0 && w < WPB) begin
        eData = memWord(16'(jobAddr + 2 * w));
        eWord = 3'(w);
        if (jobKind == 1) begin eWeD = 1; eDoneD = (w == WPB - 1); end
        else begin eWeI = 1; eDoneI = (w == WPB - 1); end
      end
    end
    chk("busy", busy, eBusy);
    chk("mem_enable", mem_enable, eEn);
    chk("mem_wr", mem_wr, eWr);
    chk("mem_data_in", mem_data_in, eDin);
    chk("store_done", store_done, eSd);
    chk("fill_we_i", fill_we_i, eWeI);
    chk("fill_we_d", fill_we_d, eWeD);
    chk("fill_done_i", fill_done_i, eDoneI);
    chk("fill_done_d", fill_done_d, eDoneD);
    chk("we_exclusive", fill_we_i & fill_we_d, 0);
    if (eEn || jobKind == 0) chk("mem_addr", mem_addr, eAddr);
    if (eWeI || eWeD || jobKind == 0) begin
      chk("fill_data", fill_data, eData);
      chk("fill_word", fill_word, eWord);
    end
  endtask

  // One clock cycle: advance model, present memory response, check, retire requests.
  task automatic step();
    int idx;
    modelAdvance();
    @(posedge clk);
    cycleNo++;
    #1;
    idx = cycleNo % 32;
    if (slotV[idx]) begin
      mem_data_valid = 1'b1;
      mem_data_out   = memWord(slotA[idx]);
      slotV[idx]     = 1'b0;
    end else if ((jobKind == 0 || jobKind == 3) &&
                 (forceSpur || (spurEn && $urandom_range(0, 3) == 0))) begin
      mem_data_valid = 1'b1;
      mem_data_out   = 16'($urandom);
    end else begin
      mem_data_valid = 1'b0;
      mem_data_out   = 16'($urandom);
    end
    @(negedge clk);
    compareNow();
    if (mem_enable && !mem_wr) begin
      slotV[(cycleNo + lat) % 32] = 1'b1;
      slotA[(cycleNo + lat) % 32] = mem_addr;
    end
    if (jobKind != 0 && jobLast()) begin
      if (jobKind == 1) dcache_miss = 1'b0;
      else if (jobKind == 2) icache_miss = 1'b0;
      else store_req = 1'b0;
    end
  endtask

  task automatic randomTraffic();
    if (!dcache_miss && jobKind != 1 && $urandom_range(0, 39) == 0) begin
      dcache_miss = 1'b1; dcache_addr = 16'($urandom);
    end
    if (!store_req && $urandom_range(0, 29) == 0) begin
      store_req = 1'b1; store_addr = 16'($urandom); store_data = 16'($urandom);
    end
    if (!icache_miss && jobKind != 2 && $urandom_range(0, 19) == 0) begin
      icache_miss = 1'b1; icache_addr = 16'($urandom);
    end
    // a requester may give up once its fill is under way
    if (icache_miss && jobKind == 2 && $urandom_range(0, 9) == 0) begin
      icache_miss = 1'b0; icache_addr = 16'($urandom);
    end
    if (dcache_miss && jobKind == 1 && $urandom_range(0, 9) == 0) begin
      dcache_miss = 1'b0; dcache_addr = 16'($urandom);
    end
  endtask

  initial begin
    int lats[4];
    lats = '{1, 3, 6, 2};
    for (int i = 0; i < 32; i++) slotV[i] = 1'b0;

    // reset
    #1 rst_n = 1'b0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_mem_enable", mem_enable, 0);
    rst_n = 1'b1;
    step();

    // 1: I miss at 0x1234, latency 4
    icache_miss = 1'b1; icache_addr = 16'h1234;
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 1)  chk("t1_first_addr", mem_addr, 16'h1230);
      if (c == 8)  chk("t1_last_addr", mem_addr, 16'h123E);
      if (c == 5)  chk("t1_first_word", {fill_we_i, fill_word}, {1'b1, 3'd0});
      if (c == 12) chk("t1_done", {fill_done_i, fill_word}, {1'b1, 3'd7});
      if (c == 13) chk("t1_idle", busy, 0);
    end

    // 2: simultaneous D and I misses
    dcache_miss = 1'b1; dcache_addr = 16'h0A08;
    icache_miss = 1'b1; icache_addr = 16'h0B10;
    for (int c = 1; c <= 26; c++) begin
      step();
      if (c == 12) chk("t2_done_d_first", {fill_done_d, fill_we_i}, {1'b1, 1'b0});
      if (c == 13) chk("t2_gap", busy, 0);
      if (c == 14) chk("t2_i_grant", mem_addr, 16'h0B10);
      if (c == 25) chk("t2_done_i", fill_done_i, 1);
      if (c == 26) chk("t2_idle", busy, 0);
    end

    // 3: write-through store
    store_req = 1'b1; store_addr = 16'h0040; store_data = 16'hBEEF;
    step();
    chk("t3_wr", {mem_enable, mem_wr, store_done, busy}, 4'b1111);
    chk("t3_addr", mem_addr, 16'h0040);
    chk("t3_data", mem_data_in, 16'hBEEF);
    step();
    chk("t3_one_cycle", busy, 0);

    // 4: reset in the middle of a D fill
    dcache_miss = 1'b1; dcache_addr = 16'h2A17;
    for (int c = 1; c <= 6; c++) step();
    rst_n = 1'b0;
    dcache_miss = 1'b0;
    jobKind = 0;
    #1;
    chk("t4_rst_outputs", {mem_enable, busy, fill_we_d, fill_done_d}, 4'b0000);
    chk("t4_rst_data", fill_data, 0);
    step(); step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("t4_late_valid", {fill_we_d, busy}, 2'b00);
    end
    dcache_miss = 1'b1; dcache_addr = 16'h3306;
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 12) chk("t4_refill_done", fill_done_d, 1);
    end

    // 5: I requester drops its miss mid-fill
    icache_miss = 1'b1; icache_addr = 16'h4F3A;
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 3) begin icache_miss = 1'b0; icache_addr = 16'hFFFF; end
      if (c == 12) chk("t5_done", {fill_done_i, fill_data}, {1'b1, memWord(16'h4F3E)});
      if (c == 13) chk("t5_idle", busy, 0);
    end

    // 6: spurious valid in idle
    forceSpur = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t6_spurious", {busy, fill_we_i, fill_we_d}, 3'b000);
    end
    forceSpur = 1'b0;

    // randomized traffic at several memory latencies
    spurEn = 1'b1;
    for (int p = 0; p < 4; p++) begin
      lat = lats[p];
      for (int c = 0; c < 800; c++) begin
        step();
        randomTraffic();
      end
      for (int c = 0; c < 600; c++) begin
        if (jobKind == 0 && !dcache_miss && !icache_miss && !store_req) break;
        step();
      end
      chk("drain_idle", jobKind, 0);
      for (int c = 0; c < 20; c++) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
